// File: rtl/mig_burst_fsm.sv
// mig_burst_fsm: BEATS-beat read/write sequencer between the core memory port
// and the MIG app_* user interface. It tracks per-beat indices, checks the
// read end marker against the beat count, and aborts stalled transactions
// through a progress watchdog.
module mig_burst_fsm #(
  parameter int         BEATS          = 2,
  parameter int         IDX_W          = $clog2(BEATS),
  parameter int         TIMEOUT_CYCLES = 1023,
  parameter logic [2:0] READ_COMMAND   = 3'b001,
  parameter logic [2:0] WRITE_COMMAND  = 3'b000
) (
  input  logic             i_mem_clk,
  input  logic             i_mem_rst,
  input  logic             i_mem_en,
  input  logic             i_mem_we,
  input  logic             i_mem_rdy,
  input  logic             i_mem_wdf_rdy,
  input  logic             i_mem_rd_valid,
  input  logic             i_mem_rd_end,
  input  logic             i_mem_rcv,
  output logic [2:0]       o_mem_cmd,
  output logic             o_mem_en,
  output logic             o_mem_wdf_wren,
  output logic             o_mem_wdf_end,
  output logic             o_mem_done,
  output logic             o_mem_err,
  output logic             o_rd_valid,
  output logic [IDX_W-1:0] o_rd_index,
  output logic [IDX_W-1:0] o_wr_index,
  output logic             o_busy
);

  // The watchdog only has to count up to TIMEOUT_CYCLES-1 before expiring.
  localparam int               WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE_READ,
    PRE_WRITE,
    READ,
    WRITE,
    DONE,
    DONE_WAIT
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] rd_cnt, rd_cnt_n;
  logic [IDX_W-1:0] wr_cnt, wr_cnt_n;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
  logic             err, err_n;

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_mem_clk) begin
    if (i_mem_rst) begin
      state  <= IDLE;
      rd_cnt <= '0;
      wr_cnt <= '0;
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      rd_cnt <= rd_cnt_n;
      wr_cnt <= wr_cnt_n;
      wd_cnt <= wd_cnt_n;
      err    <= err_n;
    end
  end

  // Next-state, counter updates and Moore/Mealy outputs.
  always_comb begin
    state_n        = state;
    rd_cnt_n       = rd_cnt;
    wr_cnt_n       = wr_cnt;
    wd_cnt_n       = wd_cnt;
    err_n          = err;
    o_mem_cmd      = '0;
    o_mem_en       = 1'b0;
    o_mem_wdf_wren = 1'b0;
    o_mem_wdf_end  = 1'b0;
    o_mem_done     = 1'b0;
    o_mem_err      = 1'b0;
    o_rd_valid     = 1'b0;
    o_rd_index     = '0;
    o_wr_index     = '0;

    unique case (state)
      IDLE: begin
        if (i_mem_en) state_n = i_mem_we ? PRE_WRITE : PRE_READ;
      end

      // Read beats may arrive in the same cycle the command is accepted, so
      // beat counting is shared between PRE_READ and READ; a last beat takes
      // priority over the command-accept transition.
      PRE_READ, READ: begin
        o_mem_cmd  = READ_COMMAND;
        o_mem_en   = (state == PRE_READ);
        o_rd_valid = i_mem_rd_valid;
        o_rd_index = rd_cnt;
        if (i_mem_rd_valid) begin
          rd_cnt_n = rd_cnt + 1'b1;
          wd_cnt_n = '0;
          if (i_mem_rd_end != (rd_cnt == LAST)) err_n = 1'b1;
          if (rd_cnt == LAST)                      state_n = DONE;
          else if (state == PRE_READ && i_mem_rdy) state_n = READ;
        end else if (state == PRE_READ && i_mem_rdy) begin
          state_n  = READ;
          wd_cnt_n = '0;
        end else if (WD_EN && wd_cnt == WD_LAST) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end

      PRE_WRITE: begin
        o_mem_cmd = WRITE_COMMAND;
        o_mem_en  = 1'b1;
        if (i_mem_rdy) begin
          state_n  = WRITE;
          wd_cnt_n = '0;
        end else if (WD_EN && wd_cnt == WD_LAST) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end

      WRITE: begin
        o_mem_cmd      = WRITE_COMMAND;
        o_mem_wdf_wren = 1'b1;
        o_mem_wdf_end  = (wr_cnt == LAST);
        o_wr_index     = wr_cnt;
        if (i_mem_wdf_rdy) begin
          wr_cnt_n = wr_cnt + 1'b1;
          wd_cnt_n = '0;
          if (wr_cnt == LAST) state_n = DONE;
        end else if (WD_EN && wd_cnt == WD_LAST) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end

      DONE: begin
        o_mem_done = 1'b1;
        o_mem_err  = err;
        if (i_mem_rcv) state_n = DONE_WAIT;
      end

      DONE_WAIT: begin
        if (!i_mem_en) begin
          state_n  = IDLE;
          rd_cnt_n = '0;
          wr_cnt_n = '0;
          wd_cnt_n = '0;
          err_n    = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_mig_burst_fsm.sv
// Scoreboard bench for mig_burst_fsm: transaction drivers push the expected
// beat/done events into a queue, and a negedge monitor pops and compares them
// whenever the DUT presents a write transfer, a read beat or a done pulse.
module tb_mig_burst_fsm;
  localparam int BEATS = 4;
  localparam int IDX_W = $clog2(BEATS);
  localparam int TO    = 8;
  localparam int MAXC  = 200;

  logic clk = 1'b0;
  logic rst, req, we, rdy, wdf_rdy, rd_valid, rd_end, rcv;
  logic [2:0]       cmd;
  logic             app_en, wdf_wren, wdf_end, done, err, rd_valid_o, busy;
  logic [IDX_W-1:0] rd_index, wr_index;
  logic [13:0]      outs;

  assign outs = {cmd, app_en, wdf_wren, wdf_end, done, err, rd_valid_o, rd_index, wr_index, busy};

  mig_burst_fsm #(.BEATS(BEATS), .TIMEOUT_CYCLES(TO)) dut (
    .i_mem_clk      (clk),
    .i_mem_rst      (rst),
    .i_mem_en       (req),
    .i_mem_we       (we),
    .i_mem_rdy      (rdy),
    .i_mem_wdf_rdy  (wdf_rdy),
    .i_mem_rd_valid (rd_valid),
    .i_mem_rd_end   (rd_end),
    .i_mem_rcv      (rcv),
    .o_mem_cmd      (cmd),
    .o_mem_en       (app_en),
    .o_mem_wdf_wren (wdf_wren),
    .o_mem_wdf_end  (wdf_end),
    .o_mem_done     (done),
    .o_mem_err      (err),
    .o_rd_valid     (rd_valid_o),
    .o_rd_index     (rd_index),
    .o_wr_index     (wr_index),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef enum int {EV_WR, EV_RD, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       idx;
    int       flag;
  } ev_t;
  ev_t expq[$];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input ev_kind_e k, input int idx, input int flag);
    ev_t e;
    e.kind = k;
    e.idx  = idx;
    e.flag = flag;
    expq.push_back(e);
  endfunction

  task automatic expect_ev(input ev_kind_e k, input int idx, input int flag);
    ev_t e;
    if (expq.size() == 0) begin
      check("unexpected_event", int'(k), -1);
    end else begin
      e = expq.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check("event_index", idx, e.idx);
      check("event_flag", flag, e.flag);
    end
  endtask

  // Monitor: one scoreboard pop per observed transfer, beat or done entry.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wdf_wren && wdf_rdy)  expect_ev(EV_WR, int'(wr_index), int'(wdf_end));
      if (rd_valid_o)           expect_ev(EV_RD, int'(rd_index), 0);
      if (done && !prev_done)   expect_ev(EV_DONE, 0, int'(err));
    end
    prev_done = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write transaction. mode 0: all ready; 1: wdf_rdy pattern 1,0,1,0,1,1; 2: random stalls.
  task automatic run_write(input int mode, output int lat, output int n_en);
    bit pat [0:5];
    int k, stall, cyc;
    bit prev_rdy, prev_wren;
    logic [IDX_W-1:0] prev_idx;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    k = 0; stall = 0; cyc = 0; prev_rdy = 1'b1; prev_wren = 1'b0; prev_idx = '0;
    for (int i = 0; i < BEATS; i++) push(EV_WR, i, (i == BEATS - 1) ? 1 : 0);
    push(EV_DONE, 0, 0);
    req = 1'b1; we = 1'b1; n_en = 0;
    while (!done && cyc < MAXC) begin
      if (mode == 2) rdy = (stall >= 3) || ($urandom_range(0, 2) != 0);
      else           rdy = 1'b1;
      if (mode == 1)      wdf_rdy = wdf_wren ? pat[(k < 6) ? k : 5] : 1'b0;
      else if (mode == 2) wdf_rdy = (stall >= 3) || ($urandom_range(0, 2) != 0);
      else                wdf_rdy = 1'b1;
      stall = ((app_en && !rdy) || (wdf_wren && !wdf_rdy)) ? stall + 1 : 0;
      if (mode == 1 && wdf_wren && prev_wren && !prev_rdy)
        check("wr_index_hold", int'(wr_index), int'(prev_idx));
      if (app_en) n_en++;
      if (wdf_wren) k++;
      prev_wren = wdf_wren; prev_rdy = wdf_rdy; prev_idx = wr_index;
      step();
      cyc++;
      we = 1'($urandom);
    end
    lat = cyc;
    if (!done) check("write_done_timeout", 0, 1);
  endtask

  // Read transaction. mode 0: correct end marker; 1: end on 2nd beat only; 2: random.
  task automatic run_read(input int mode);
    bit ends [BEATS];
    int gap  [BEATS];
    int exp_err, cyc, b, wait_c, stall, last_step;
    bit accepted;
    exp_err = 0; cyc = 0; b = 0; stall = 0; accepted = 1'b0; last_step = -1;
    for (int i = 0; i < BEATS; i++) begin
      ends[i] = (mode == 1) ? (i == 1) : (i == BEATS - 1);
      gap[i]  = (mode == 2) ? $urandom_range(0, 4) : ((i == 0) ? 2 : 0);
    end
    if (mode == 2 && $urandom_range(0, 3) == 0)
      for (int i = 0; i < BEATS; i++) ends[i] = 1'($urandom);
    for (int i = 0; i < BEATS; i++) begin
      if (ends[i] != (i == BEATS - 1)) exp_err = 1;
      push(EV_RD, i, 0);
    end
    push(EV_DONE, 0, exp_err);
    req = 1'b1; we = 1'b0; wait_c = gap[0];
    while (!done && cyc < MAXC) begin
      rd_valid = 1'b0; rd_end = 1'b0;
      if (!accepted) begin
        rdy   = (mode != 2) || (stall >= 3) || ($urandom_range(0, 2) != 0);
        stall = (app_en && !rdy) ? stall + 1 : 0;
        if (app_en && rdy) accepted = 1'b1;
      end else begin
        rdy = 1'($urandom);
        if (wait_c > 0) wait_c--;
        else if (b < BEATS) begin
          rd_valid = 1'b1;
          rd_end   = ends[b];
          b++;
          if (b < BEATS) wait_c = gap[b];
          else           last_step = cyc + 1;
        end
      end
      step();
      cyc++;
      we = 1'($urandom);
    end
    rd_valid = 1'b0; rd_end = 1'b0;
    if (!done) check("read_done_timeout", 0, 1);
    check("read_done_latency", cyc, last_step);
  endtask

  task automatic finish_txn(input int delay);
    for (int i = 0; i < delay; i++) begin
      check("done_held", int'(done), 1);
      step();
    end
    rcv = 1'b1;
    step();
    check("done_released", int'(done), 0);
    check("in_done_wait", int'(busy), 1);
    rcv = 1'b0; req = 1'b0;
    step();
    check("back_idle", int'(busy), 0);
    check("err_cleared", int'(err), 0);
  endtask

  initial begin
    int lat, n_en, cyc;
    rst = 1'b1; req = 1'b0; we = 1'b0; rdy = 1'b1; wdf_rdy = 1'b1;
    rd_valid = 1'b0; rd_end = 1'b0; rcv = 1'b0;
    repeat (3) step();
    check("reset_outputs", int'(outs), 0);
    rst = 1'b0;
    step();

    // Directed write: latency 2+BEATS, app_en for one cycle.
    run_write(0, lat, n_en);
    check("write_latency", lat, 2 + BEATS);
    check("write_app_en_cycles", n_en, 1);
    finish_txn(0);

    run_write(1, lat, n_en);
    finish_txn(1);

    run_read(0);
    finish_txn(0);
    run_read(1);
    finish_txn(2);

    // Watchdog: command never accepted.
    push(EV_DONE, 0, 1);
    req = 1'b1; we = 1'b0; rdy = 1'b0; n_en = 0; cyc = 0;
    while (!done && cyc < MAXC) begin
      if (app_en) n_en++;
      step();
      cyc++;
    end
    check("timeout_pre_read_cycles", n_en, TO);
    check("timeout_app_en_low", int'(app_en), 0);
    check("timeout_err", int'(err), 1);
    rdy = 1'b1;
    finish_txn(1);

    // Request held high through DONE_WAIT must not restart.
    run_write(0, lat, n_en);
    rcv = 1'b1;
    step();
    rcv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_no_cmd", int'(app_en), 0);
      check("hold_busy", int'(busy), 1);
      step();
    end
    req = 1'b0;
    step();
    check("hold_release_idle", int'(busy), 0);
    run_read(0);
    finish_txn(0);

    // Reset during the third write beat.
    push(EV_WR, 0, 0);
    push(EV_WR, 1, 0);
    req = 1'b1; we = 1'b1; rdy = 1'b1; wdf_rdy = 1'b1; cyc = 0;
    while (!(wdf_wren && wr_index == IDX_W'(2)) && cyc < MAXC) begin
      step();
      cyc++;
    end
    check("reached_third_beat", int'(wr_index), 2);
    rst = 1'b1; rd_valid = 1'b1;
    step();
    check("midreset_outputs", int'(outs), 0);
    step();
    check("midreset_held", int'(outs), 0);
    rst = 1'b0; rd_valid = 1'b0; req = 1'b0;
    step();
    check("midreset_queue", expq.size(), 0);
    run_read(0);
    finish_txn(0);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) run_write(2, lat, n_en);
      else                           run_read(2);
      finish_txn($urandom_range(0, 2));
    end

    repeat (3) step();
    check("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
